// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one six-digit hex display among NUM_REQ requesters.
// The granted 10-bit two's-complement value is shown as sign (LED) plus hex magnitude.
//
// state | meaning
// IDLE  | display blank, searching for the next requester from rr_ptr
// LOAD  | one cycle: capture winner's value, convert to sign/magnitude
// HOLD  | display granted value for HOLD_CYCLES clocks, then ack
module hex_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [10*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   grant_valid,
  output logic [1:0]             grant_idx,
  output logic                   neg,
  output logic [4:0]             nib5,
  output logic [4:0]             nib4,
  output logic [4:0]             nib3,
  output logic [4:0]             nib2,
  output logic [4:0]             nib1,
  output logic [4:0]             nib0
);

  localparam logic [4:0]       NIB_OFF  = 5'b10000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_ptr_q, idx_q, winner, cand;
  logic             found;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       mag_q, v;
  logic             neg_q;
  logic [3:0]       req_pad, ack_pad;
  logic [9:0]       data_arr [4];
  logic             cur_req, last_cycle;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (int'(p) == NUM_REQ - 1) ? 2'd0 : p + 2'd1;
  endfunction

  // Pad to the 4-requester maximum so 2-bit indices are always in range.
  assign req_pad = 4'(req);
  for (genvar i = 0; i < 4; i++) begin : g_data
    if (i < NUM_REQ) begin : g_real
      assign data_arr[i] = data[10*i +: 10];
    end else begin : g_none
      assign data_arr[i] = '0;
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_pad[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign v          = data_arr[idx_q];
  assign cur_req    = req_pad[idx_q];
  assign last_cycle = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    grant_valid = 1'b0;
    ack_pad     = '0;
    unique case (state_q)
      IDLE: if (found) state_d = LOAD;
      LOAD: state_d = HOLD;
      HOLD: begin
        grant_valid = 1'b1;
        // A dropped request aborts the grant and suppresses the ack.
        if (!cur_req) begin
          state_d = IDLE;
        end else if (last_cycle) begin
          state_d        = IDLE;
          ack_pad[idx_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (found) idx_q <= winner;
        LOAD: begin
          mag_q <= v[9] ? (~v + 10'd1) : v;
          neg_q <= v[9];
          cnt_q <= '0;
        end
        HOLD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (state_d == IDLE) rr_ptr_q <= wrap_inc(idx_q);
        end
        default: ;
      endcase
    end
  end

  assign ack       = ack_pad[NUM_REQ-1:0];
  assign grant_idx = idx_q;
  assign neg       = neg_q & grant_valid;

  // Leading-zero blanking on the magnitude digits; the lowest digit always shows.
  always_comb begin
    nib5 = NIB_OFF;
    nib4 = NIB_OFF;
    nib3 = NIB_OFF;
    nib2 = NIB_OFF;
    nib1 = NIB_OFF;
    nib0 = NIB_OFF;
    if (grant_valid) begin
      nib5 = {3'b000, idx_q};
      if (mag_q[9:8] != 2'b00) nib2 = {3'b000, mag_q[9:8]};
      if (mag_q[9:4] != 6'd0)  nib1 = {1'b0, mag_q[7:4]};
      nib0 = {1'b0, mag_q[3:0]};
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with HOLD_CYCLES=4: vector table for the
// first two grants, then hand sequences for round-robin, data freeze, abort and reset.
module tb_hex_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HOLD    = 4;
  localparam logic [4:0] OFF = 5'h10;
  localparam logic [37:0] ALL = '1;
  localparam logic [37:0] NO_IDX = ~(38'h3 << 31);

  logic        clk, rst_n;
  logic [3:0]  req;
  logic [39:0] data;
  logic [3:0]  ack;
  logic        grant_valid, neg;
  logic [1:0]  grant_idx;
  logic [4:0]  nib5, nib4, nib3, nib2, nib1, nib0;

  int total = 0;
  int bad   = 0;

  hex_display_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .neg(neg),
    .nib5(nib5), .nib4(nib4), .nib3(nib3), .nib2(nib2), .nib1(nib1), .nib0(nib0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [39:0] data;
    logic [37:0] exp;
  } vec_t;

  vec_t tbl [14];

  // Bundle layout: {ack, grant_valid, grant_idx, neg, nib5..nib0}
  function automatic logic [37:0] exp_v(input bit gv, input logic [1:0] idx, input bit ng,
                                        input logic [3:0] ak, input logic [4:0] n2,
                                        input logic [4:0] n1, input logic [4:0] n0);
    if (gv) return {ak, 1'b1, idx, ng, {3'b000, idx}, OFF, OFF, n2, n1, n0};
    return {ak, 1'b0, idx, 1'b0, OFF, OFF, OFF, OFF, OFF, OFF};
  endfunction

  task automatic check(input string name, input logic [37:0] exp, input logic [37:0] mask);
    logic [37:0] got;
    got = {ack, grant_valid, grant_idx, neg, nib5, nib4, nib3, nib2, nib1, nib0};
    total++;
    if ((got & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got & mask, exp & mask);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with the winner's request already driven; ends in IDLE after the ack.
  task automatic run_grant(input logic [1:0] idx, input logic [4:0] n2, input logic [4:0] n1,
                           input logic [4:0] n0, input bit ng, input bit chg_data2);
    check($sformatf("gap_idle_r%0d", idx), exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF), NO_IDX);
    step();
    check($sformatf("gap_load_r%0d", idx), exp_v(0, idx, 0, 4'd0, OFF, OFF, OFF), ALL);
    step();
    for (int c = 0; c < HOLD; c++) begin
      if (chg_data2 && c == 1) begin
        data[29:20] = 10'h005;
        #1;
      end
      check($sformatf("hold_r%0d_c%0d", idx, c),
            exp_v(1, idx, ng, (c == HOLD - 1) ? (4'b0001 << idx) : 4'd0, n2, n1, n0), ALL);
      step();
    end
  endtask

  initial begin
    logic [39:0] d_a;
    d_a = {10'h000, 10'h000, 10'h3FF, 10'h07B};
    for (int i = 0; i < 14; i++) tbl[i].data = d_a;
    tbl[0].req  = 4'b0001; tbl[0].exp  = exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF);
    tbl[1].req  = 4'b0001; tbl[1].exp  = exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF);
    tbl[2].req  = 4'b0001; tbl[2].exp  = exp_v(1, 2'd0, 0, 4'd0, OFF, 5'h07, 5'h0B);
    tbl[3].req  = 4'b0001; tbl[3].exp  = exp_v(1, 2'd0, 0, 4'd0, OFF, 5'h07, 5'h0B);
    tbl[4].req  = 4'b0001; tbl[4].exp  = exp_v(1, 2'd0, 0, 4'd0, OFF, 5'h07, 5'h0B);
    tbl[5].req  = 4'b0001; tbl[5].exp  = exp_v(1, 2'd0, 0, 4'b0001, OFF, 5'h07, 5'h0B);
    tbl[6].req  = 4'b0000; tbl[6].exp  = exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF);
    tbl[7].req  = 4'b0010; tbl[7].exp  = exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF);
    tbl[8].req  = 4'b0010; tbl[8].exp  = exp_v(0, 2'd1, 0, 4'd0, OFF, OFF, OFF);
    tbl[9].req  = 4'b0010; tbl[9].exp  = exp_v(1, 2'd1, 1, 4'd0, OFF, OFF, 5'h01);
    tbl[10].req = 4'b0010; tbl[10].exp = exp_v(1, 2'd1, 1, 4'd0, OFF, OFF, 5'h01);
    tbl[11].req = 4'b0010; tbl[11].exp = exp_v(1, 2'd1, 1, 4'd0, OFF, OFF, 5'h01);
    tbl[12].req = 4'b0010; tbl[12].exp = exp_v(1, 2'd1, 1, 4'b0010, OFF, OFF, 5'h01);
    tbl[13].req = 4'b0000; tbl[13].exp = exp_v(0, 2'd1, 0, 4'd0, OFF, OFF, OFF);

    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    step();
    step();
    check("reset", exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF), ALL);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      req  = tbl[i].req;
      data = tbl[i].data;
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp, ALL);
      step();
    end

    // Round robin with all requesting; requester 2's data changes mid-hold.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    data = {10'h1A5, 10'h200, 10'h3FF, 10'h07B};
    req  = 4'b1111;
    #1;
    run_grant(2'd0, OFF, 5'h07, 5'h0B, 0, 0);
    run_grant(2'd1, OFF, OFF, 5'h01, 1, 0);
    run_grant(2'd2, 5'h02, 5'h00, 5'h00, 1, 1);
    run_grant(2'd3, 5'h01, 5'h0A, 5'h05, 0, 0);
    run_grant(2'd0, OFF, 5'h07, 5'h0B, 0, 0);
    run_grant(2'd1, OFF, OFF, 5'h01, 1, 0);
    run_grant(2'd2, OFF, OFF, 5'h05, 0, 0);

    // Reset pulse in the middle of requester 3's hold.
    check("mr_idle", exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF), NO_IDX);
    step();
    step();
    check("mr_hold_c0", exp_v(1, 2'd3, 0, 4'd0, 5'h01, 5'h0A, 5'h05), ALL);
    step();
    check("mr_hold_c1", exp_v(1, 2'd3, 0, 4'd0, 5'h01, 5'h0A, 5'h05), ALL);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mr_after_rst", exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF), ALL);
    run_grant(2'd0, OFF, 5'h07, 5'h0B, 0, 0);

    // Requester 1 drops its request in its second hold cycle.
    req = 4'b0110;
    #1;
    check("ab_idle", exp_v(0, 2'd0, 0, 4'd0, OFF, OFF, OFF), NO_IDX);
    step();
    check("ab_load", exp_v(0, 2'd1, 0, 4'd0, OFF, OFF, OFF), ALL);
    step();
    check("ab_hold_c0", exp_v(1, 2'd1, 1, 4'd0, OFF, OFF, 5'h01), ALL);
    step();
    req = 4'b0100;
    #1;
    check("ab_hold_c1", exp_v(1, 2'd1, 1, 4'd0, OFF, OFF, 5'h01), ALL);
    step();
    check("ab_released", exp_v(0, 2'd1, 0, 4'd0, OFF, OFF, OFF), ALL);
    run_grant(2'd2, OFF, OFF, 5'h05, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
